// File: rtl/multi_signal_measure_pkg.sv
// Shared constants for the multi-channel frequency/duty meter: FSM state
// encoding and the divider width rule.
package multi_signal_measure_pkg;

    localparam int DIV_HEADROOM = 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARM   = 3'd1;
    localparam logic [2:0] ST_MEAS  = 3'd2;
    localparam logic [2:0] ST_DIV_F = 3'd3;
    localparam logic [2:0] ST_DIV_D = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    // Headroom covers CLK_FREQ*255 and high_cnt*100 without overflow.
    function automatic int div_width(input int cnt_w);
        return cnt_w + DIV_HEADROOM;
    endfunction

endpackage

// File: rtl/multi_signal_measure_div.sv
// Restoring unsigned divider, one quotient bit per clock.
// start_i loads the operands; done_o pulses once the quotient is final.
module multi_signal_measure_div #(
    parameter int W = 40
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         start_i,
    input  logic [W-1:0] dividend_i,
    input  logic [W-1:0] divisor_i,
    output logic [W-1:0] quotient_o,
    output logic         done_o
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;

    logic [W:0]    rem_sh;
    logic [W:0]    diff;
    logic          fits;

    assign rem_sh = {rem_q, quo_q[W-1]};
    assign fits   = (rem_sh >= {1'b0, dvs_q});
    assign diff   = rem_sh - {1'b0, dvs_q};

    always_comb begin
        quo_d  = quo_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (start_i) begin
            quo_d = dividend_i;
            rem_d = '0;
            dvs_d = divisor_i;
            cnt_d = CW'(W);
        end else if (cnt_q != '0) begin
            rem_d  = fits ? diff[W-1:0] : rem_sh[W-1:0];
            quo_d  = {quo_q[W-2:0], fits};
            cnt_d  = cnt_q - CW'(1);
            done_d = (cnt_q == CW'(1));
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign quotient_o = quo_q;
    assign done_o     = done_q;

endmodule

// File: rtl/multi_signal_measure.sv
// Multi-channel frequency/duty meter: measures one synchronised input over
// n whole periods, then derives frequency and duty with a shared divider.
//
// state  | meaning
// IDLE   | waiting for start, outputs hold last result
// ARM    | waiting for first rising edge of selected channel
// MEAS   | counting high/low clocks over n periods
// DIV_F  | dividing CLK_FREQ*n by period sum
// DIV_D  | dividing high*100 by period sum
// DONE   | one-cycle done pulse, results registered on entry
module multi_signal_measure
    import multi_signal_measure_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 32,
    parameter int TIMEOUT_CYC = 50_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      start_i,
    input  logic [$clog2(NUM_CH)-1:0] ch_sel_i,
    input  logic [7:0]                n_periods_i,
    input  logic [NUM_CH-1:0]         sig_in_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      timeout_o,
    output logic [CNT_W-1:0]          freq_o,
    output logic [7:0]                duty_o,
    output logic [CNT_W-1:0]          high_cnt_o,
    output logic [CNT_W-1:0]          low_cnt_o
);

    localparam int DIV_W = div_width(CNT_W);
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam logic [DIV_W-1:0] CLK_FREQ_W = DIV_W'(CLK_FREQ);

    logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
    logic              sig_s;
    logic              sig_d_q, sig_d_d;
    logic              rise;

    logic [2:0]        state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [7:0]        n_q, n_d;
    logic [7:0]        ecnt_q, ecnt_d;
    logic [CNT_W-1:0]  hcnt_q, hcnt_d;
    logic [CNT_W-1:0]  lcnt_q, lcnt_d;
    logic [TO_W-1:0]   tcnt_q, tcnt_d;
    logic [CNT_W-1:0]  freq_tmp_q, freq_tmp_d;
    logic              div_start_q, div_start_d;
    logic [DIV_W-1:0]  div_a_q, div_a_d;
    logic [DIV_W-1:0]  div_b_q, div_b_d;

    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  freq_q, freq_d;
    logic [7:0]        duty_q, duty_d;
    logic [CNT_W-1:0]  high_q, high_d;
    logic [CNT_W-1:0]  low_q, low_d;

    logic [DIV_W-1:0]  div_quo;
    logic              div_done;

    logic [CNT_W-1:0]  hcnt_inc, lcnt_inc;
    logic [DIV_W-1:0]  period_sum, freq_num, duty_num;
    logic [CNT_W-1:0]  freq_sat;
    logic              last_edge, timeout_hit;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= sig_in_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign sig_s = sync_q[SYNC_STAGES-1][ch_q];
    assign rise  = sig_s & ~sig_d_q;

    // Preload the edge register from the newly selected channel so a channel
    // switch cannot look like a rising edge in the first ARM cycle.
    assign sig_d_d = (state_q == ST_IDLE && start_i) ?
                     sync_q[SYNC_STAGES-1][ch_sel_i] : sig_s;

    assign hcnt_inc    = (&hcnt_q) ? hcnt_q : hcnt_q + CNT_W'(1);
    assign lcnt_inc    = (&lcnt_q) ? lcnt_q : lcnt_q + CNT_W'(1);
    assign period_sum  = {{(DIV_W-CNT_W){1'b0}}, hcnt_q} + {{(DIV_W-CNT_W){1'b0}}, lcnt_q};
    assign freq_num    = CLK_FREQ_W * {{(DIV_W-8){1'b0}}, n_q};
    assign duty_num    = {{(DIV_W-CNT_W){1'b0}}, hcnt_q} * DIV_W'(100);
    assign freq_sat    = (|div_quo[DIV_W-1:CNT_W]) ? '1 : div_quo[CNT_W-1:0];
    assign last_edge   = ({1'b0, ecnt_q} + 9'd1) == {1'b0, n_q};
    assign timeout_hit = (tcnt_q == TO_W'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        n_d         = n_q;
        ecnt_d      = ecnt_q;
        hcnt_d      = hcnt_q;
        lcnt_d      = lcnt_q;
        tcnt_d      = tcnt_q;
        freq_tmp_d  = freq_tmp_q;
        div_start_d = 1'b0;
        div_a_d     = div_a_q;
        div_b_d     = div_b_q;
        timeout_d   = timeout_q;
        freq_d      = freq_q;
        duty_d      = duty_q;
        high_d      = high_q;
        low_d       = low_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    ch_d    = ch_sel_i;
                    n_d     = (n_periods_i == 8'd0) ? 8'd1 : n_periods_i;
                    tcnt_d  = '0;
                    hcnt_d  = '0;
                    lcnt_d  = '0;
                    ecnt_d  = '0;
                    state_d = ST_ARM;
                end
            end
            ST_ARM, ST_MEAS: begin
                if (timeout_hit) begin
                    timeout_d = 1'b1;
                    freq_d    = '0;
                    duty_d    = '0;
                    high_d    = hcnt_q;
                    low_d     = lcnt_q;
                    state_d   = ST_DONE;
                end else begin
                    tcnt_d = tcnt_q + TO_W'(1);
                    if (state_q == ST_ARM) begin
                        if (rise) begin
                            hcnt_d  = CNT_W'(1);
                            lcnt_d  = '0;
                            ecnt_d  = '0;
                            state_d = ST_MEAS;
                        end
                    end else if (rise) begin
                        if (last_edge) begin
                            div_start_d = 1'b1;
                            div_a_d     = freq_num;
                            div_b_d     = period_sum;
                            state_d     = ST_DIV_F;
                        end else begin
                            ecnt_d = ecnt_q + 8'd1;
                            hcnt_d = hcnt_inc;
                        end
                    end else if (sig_s) begin
                        hcnt_d = hcnt_inc;
                    end else begin
                        lcnt_d = lcnt_inc;
                    end
                end
            end
            ST_DIV_F: begin
                if (div_done) begin
                    freq_tmp_d  = freq_sat;
                    div_start_d = 1'b1;
                    div_a_d     = duty_num;
                    div_b_d     = period_sum;
                    state_d     = ST_DIV_D;
                end
            end
            ST_DIV_D: begin
                if (div_done) begin
                    timeout_d = 1'b0;
                    freq_d    = freq_tmp_q;
                    duty_d    = div_quo[7:0];
                    high_d    = hcnt_q;
                    low_d     = lcnt_q;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sig_d_q     <= 1'b0;
            state_q     <= ST_IDLE;
            ch_q        <= '0;
            n_q         <= 8'd1;
            ecnt_q      <= '0;
            hcnt_q      <= '0;
            lcnt_q      <= '0;
            tcnt_q      <= '0;
            freq_tmp_q  <= '0;
            div_start_q <= 1'b0;
            div_a_q     <= '0;
            div_b_q     <= '0;
            timeout_q   <= 1'b0;
            freq_q      <= '0;
            duty_q      <= '0;
            high_q      <= '0;
            low_q       <= '0;
        end else begin
            sig_d_q     <= sig_d_d;
            state_q     <= state_d;
            ch_q        <= ch_d;
            n_q         <= n_d;
            ecnt_q      <= ecnt_d;
            hcnt_q      <= hcnt_d;
            lcnt_q      <= lcnt_d;
            tcnt_q      <= tcnt_d;
            freq_tmp_q  <= freq_tmp_d;
            div_start_q <= div_start_d;
            div_a_q     <= div_a_d;
            div_b_q     <= div_b_d;
            timeout_q   <= timeout_d;
            freq_q      <= freq_d;
            duty_q      <= duty_d;
            high_q      <= high_d;
            low_q       <= low_d;
        end
    end

    multi_signal_measure_div #(
        .W(DIV_W)
    ) u_div (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .start_i    (div_start_q),
        .dividend_i (div_a_q),
        .divisor_i  (div_b_q),
        .quotient_o (div_quo),
        .done_o     (div_done)
    );

    assign busy_o     = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done_o     = (state_q == ST_DONE);
    assign timeout_o  = timeout_q;
    assign freq_o     = freq_q;
    assign duty_o     = duty_q;
    assign high_cnt_o = high_q;
    assign low_cnt_o  = low_q;

endmodule

// File: tb/tb_multi_signal_measure.sv
// Bench for multi_signal_measure: per-channel square-wave generators and an
// arithmetic model of the expected counts, frequency and duty.
module tb_multi_signal_measure;

    localparam int CLK_FREQ = 50_000_000;
    localparam int TO_CYC   = 1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  ch_sel = '0;
    logic [7:0]  n_per = '0;
    logic [3:0]  sig = '0;
    logic        busy_o, done_o, timeout_o;
    logic [31:0] freq_o, high_o, low_o;
    logic [7:0]  duty_o;

    int per_c [4];
    int hi_c  [4];
    int ph    [4];
    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;

    multi_signal_measure #(
        .CLK_FREQ(CLK_FREQ), .NUM_CH(4), .CNT_W(32),
        .TIMEOUT_CYC(TO_CYC), .SYNC_STAGES(2)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .ch_sel_i(ch_sel),
        .n_periods_i(n_per), .sig_in_i(sig), .busy_o(busy_o), .done_o(done_o),
        .timeout_o(timeout_o), .freq_o(freq_o), .duty_o(duty_o),
        .high_cnt_o(high_o), .low_cnt_o(low_o)
    );

    always #10 clk = ~clk;

    // Each channel: period per_c clocks, high for the first hi_c clocks.
    always @(negedge clk) begin
        for (int c = 0; c < 4; c++) begin
            if (per_c[c] < 2) begin
                sig[c] = 1'b0;
            end else begin
                ph[c]  = (ph[c] + 1) % per_c[c];
                sig[c] = (ph[c] < hi_c[c]);
            end
        end
    end

    always @(negedge clk) if (done_o) done_cnt++;

    initial begin
        #5ms;
        $display("FAIL watchdog: observed no end of run, expected finish");
        $fatal(1);
    end

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_ch(input int c, input int p, input int h);
        per_c[c] = p;
        hi_c[c]  = h;
    endtask

    task automatic run_meas(input string tag, input int ch, input int nin, input int extra_at);
        int     neff;
        longint eh, el, ef, ed;
        bit     got;
        neff = (nin == 0) ? 1 : nin;
        eh = longint'(neff) * hi_c[ch];
        el = longint'(neff) * (per_c[ch] - hi_c[ch]);
        ef = longint'(CLK_FREQ) * neff / (eh + el);
        ed = eh * 100 / (eh + el);
        @(negedge clk);
        ch_sel = 2'(ch);
        n_per  = 8'(nin);
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val({tag, ".busy_after_start"}, busy_o, 1);
        got = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (done_o) begin
                got = 1'b1;
                break;
            end
            if (cyc == extra_at) begin
                start  = 1'b1;
                ch_sel = 2'(ch + 1);
                n_per  = 8'(nin + 3);
            end
            if (cyc == extra_at + 1) start = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        check_val({tag, ".done_seen"}, got, 1);
        if (got) begin
            check_val({tag, ".high_cnt"}, high_o, eh);
            check_val({tag, ".low_cnt"},  low_o,  el);
            check_val({tag, ".freq"},     freq_o, ef);
            check_val({tag, ".duty"},     duty_o, ed);
            check_val({tag, ".timeout"},  timeout_o, 0);
            check_val({tag, ".busy_at_done"}, busy_o, 0);
        end
    endtask

    task automatic run_timeout(input string tag, input int ch);
        bit got;
        bit prev_busy;
        int lat;
        @(negedge clk);
        ch_sel = 2'(ch);
        n_per  = 8'd2;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got = 1'b0;
        lat = 0;
        prev_busy = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (done_o) begin
                got = 1'b1;
                lat = cyc;
                break;
            end
            prev_busy = busy_o;
            @(negedge clk);
        end
        check_val({tag, ".done_seen"}, got, 1);
        if (got) begin
            check_val({tag, ".latency_near_limit"}, (lat >= TO_CYC - 10 && lat <= TO_CYC + 10), 1);
            check_val({tag, ".timeout"}, timeout_o, 1);
            check_val({tag, ".freq"}, freq_o, 0);
            check_val({tag, ".duty"}, duty_o, 0);
            check_val({tag, ".high_cnt"}, high_o, 0);
            check_val({tag, ".low_cnt"}, low_o, 0);
            check_val({tag, ".busy_before_done"}, prev_busy, 1);
            check_val({tag, ".busy_at_done"}, busy_o, 0);
        end
    endtask

    initial begin
        int dc;
        for (int c = 0; c < 4; c++) begin
            ph[c] = 0;
            set_ch(c, 100, 40);
        end
        repeat (3) @(negedge clk);
        check_val("rst.busy", busy_o, 0);
        check_val("rst.done", done_o, 0);
        check_val("rst.timeout", timeout_o, 0);
        check_val("rst.freq", freq_o, 0);
        check_val("rst.duty", duty_o, 0);
        check_val("rst.high", high_o, 0);
        check_val("rst.low", low_o, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        run_meas("t1", 0, 1, -1);

        set_ch(0, 50, 25);
        repeat (5) @(negedge clk);
        run_meas("t2", 0, 4, -1);

        set_ch(0, 50, 25);
        set_ch(1, 50, 25);
        set_ch(3, 50, 25);
        set_ch(2, 20, 5);
        repeat (5) @(negedge clk);
        run_meas("t3", 2, 8, -1);

        set_ch(1, 0, 0);
        repeat (5) @(negedge clk);
        run_timeout("t4", 1);

        set_ch(0, 100, 40);
        repeat (5) @(negedge clk);
        dc = done_cnt;
        run_meas("t5a", 0, 1, 120);
        repeat (300) @(negedge clk);
        check_val("t5a.one_done", done_cnt - dc, 1);
        check_val("t5a.idle_after", busy_o, 0);
        run_meas("t5b", 0, 0, -1);

        set_ch(0, 100, 25);
        repeat (5) @(negedge clk);
        ch_sel = 2'd0;
        n_per  = 8'd4;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (200) @(negedge clk);
        dc = done_cnt;
        #5 rst_n = 1'b0;
        #1;
        check_val("t6.rst_busy", busy_o, 0);
        check_val("t6.rst_done", done_o, 0);
        check_val("t6.rst_timeout", timeout_o, 0);
        check_val("t6.rst_freq", freq_o, 0);
        check_val("t6.rst_duty", duty_o, 0);
        check_val("t6.rst_high", high_o, 0);
        check_val("t6.rst_low", low_o, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (600) @(negedge clk);
        check_val("t6.no_done", done_cnt - dc, 0);
        run_meas("t6b", 0, 4, -1);

        for (int r = 0; r < 8; r++) begin
            int p;
            for (int c = 0; c < 4; c++) begin
                p = int'($urandom_range(60, 4));
                set_ch(c, p, int'($urandom_range(p - 1, 1)));
            end
            repeat (3) @(negedge clk);
            run_meas($sformatf("rnd%0d", r), int'($urandom_range(3, 0)),
                     int'($urandom_range(10, 0)), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
